// File: rtl/prog_ctr_seq_pkg.sv
// Shared types and default widths for the program-counter sequencer.
// Imported by the interface, the next-PC calculator and the top.
package prog_ctr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int PC_W_DEF   = 10;
    localparam int OFF_W_DEF  = 8;
    localparam int CNT_W_DEF  = 16;
    localparam bit BR_ABS_DEF = 1'b0;

endpackage

// File: rtl/prog_ctr_seq_if.sv
// Control/status bundle between the decoder side and the PC sequencer.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface prog_ctr_seq_if
    import prog_ctr_seq_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic             Stall;
    logic             BranchOnEq;
    logic             BranchOnNe;
    logic             Ack;
    logic             EqFlag;
    logic [OFF_W-1:0] BrTarget;
    logic [PC_W-1:0]  InstrAddr;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output Start, StartAddr, Stall,
        output BranchOnEq, BranchOnNe,
        output Ack, EqFlag, BrTarget,
        input  InstrAddr, Running, Done,
        input  InstrCount
    );

    modport slave (
        input  Start, StartAddr, Stall,
        input  BranchOnEq, BranchOnNe,
        input  Ack, EqFlag, BrTarget,
        output InstrAddr, Running, Done,
        output InstrCount
    );

endinterface

// File: rtl/prog_ctr_seq_pc_next_calc.sv
// Combinational next-PC: increment, relative or absolute branch.
// All arithmetic wraps modulo 2^PC_W.
module prog_ctr_seq_pc_next_calc
    import prog_ctr_seq_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int OFF_W  = OFF_W_DEF,
    parameter bit BR_ABS = BR_ABS_DEF
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             taken,
    input  logic [OFF_W-1:0] br_target,
    output logic [PC_W-1:0]  pc_next
);

    logic [PC_W-1:0] off_sext;
    logic [PC_W-1:0] off_zext;
    logic [PC_W-1:0] br_pc;

    assign off_sext = PC_W'($signed(br_target));
    assign off_zext = PC_W'(br_target);

    assign br_pc = BR_ABS ? off_zext : pc + off_sext;

    assign pc_next = taken ? br_pc : pc + PC_W'(1);

endmodule

// File: rtl/prog_ctr_seq.sv
// PC sequencer: IDLE/RUN/HALT FSM, program counter and
// saturating retired-instruction counter.
module prog_ctr_seq
    import prog_ctr_seq_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int OFF_W  = OFF_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter bit BR_ABS = BR_ABS_DEF
) (
    input logic          Clk,
    input logic          Reset,
    prog_ctr_seq_if.slave bus
);

    pc_state_t        state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             taken;
    logic             running;
    logic             done;

    // Both branch bits set is an illegal decode; it falls out as taken.
    assign taken = (bus.BranchOnEq & bus.EqFlag)
                 | (bus.BranchOnNe & ~bus.EqFlag);

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    prog_ctr_seq_pc_next_calc #(
        .PC_W   (PC_W),
        .OFF_W  (OFF_W),
        .BR_ABS (BR_ABS)
    ) u_next (
        .pc        (pc),
        .taken     (taken),
        .br_target (bus.BrTarget),
        .pc_next   (pc_nxt)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            pc      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (bus.Start) begin
            state   <= RUN;
            pc      <= bus.StartAddr;
            cnt     <= '0;
            running <= 1'b1;
            done    <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.Stall) begin
                        state <= RUN;
                    end else if (bus.Ack) begin
                        state   <= HALT;
                        cnt     <= cnt_inc;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        pc  <= pc_nxt;
                        cnt <= cnt_inc;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.InstrAddr  = pc;
    assign bus.Running    = running;
    assign bus.Done       = done;
    assign bus.InstrCount = cnt;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Directed bench for prog_ctr_seq: relative-branch DUT plus
// an absolute-branch DUT for the BR_ABS=1 path.
module tb_prog_ctr_seq;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    prog_ctr_seq_if #(.PC_W(10), .OFF_W(8), .CNT_W(16)) a ();
    prog_ctr_seq_if #(.PC_W(10), .OFF_W(8), .CNT_W(16)) b ();

    prog_ctr_seq #(.BR_ABS(1'b0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (a)
    );

    prog_ctr_seq #(.BR_ABS(1'b1)) dut_abs (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr_a();
        a.Start      = 1'b0;
        a.StartAddr  = '0;
        a.Stall      = 1'b0;
        a.BranchOnEq = 1'b0;
        a.BranchOnNe = 1'b0;
        a.Ack        = 1'b0;
        a.EqFlag     = 1'b0;
        a.BrTarget   = '0;
    endtask

    task automatic start_a(input logic [9:0] addr);
        a.Start     = 1'b1;
        a.StartAddr = addr;
        tick();
        a.Start     = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b0;
        clr_a();
        b.Start      = 1'b0;
        b.StartAddr  = '0;
        b.Stall      = 1'b0;
        b.BranchOnEq = 1'b0;
        b.BranchOnNe = 1'b0;
        b.Ack        = 1'b0;
        b.EqFlag     = 1'b0;
        b.BrTarget   = '0;
        #12;
        chk("rst_pc", 32'(a.InstrAddr), 32'h0);
        chk("rst_run", 32'(a.Running), 32'h0);
        chk("rst_done", 32'(a.Done), 32'h0);
        chk("rst_cnt", 32'(a.InstrCount), 32'h0);
        Reset = 1'b1;
        tick();
        tick();
        chk("idle_pc", 32'(a.InstrAddr), 32'h0);
        chk("idle_run", 32'(a.Running), 32'h0);

        start_a(10'h010);
        chk("seq_pc0", 32'(a.InstrAddr), 32'h010);
        chk("seq_run", 32'(a.Running), 32'h1);
        chk("seq_cnt0", 32'(a.InstrCount), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_pc", 32'(a.InstrAddr), 32'h010 + 32'(i));
        end
        chk("seq_cnt5", 32'(a.InstrCount), 32'h5);

        start_a(10'h020);
        a.BranchOnEq = 1'b1;
        a.EqFlag     = 1'b1;
        a.BrTarget   = 8'hF8;
        tick();
        chk("beq_tk", 32'(a.InstrAddr), 32'h018);
        chk("beq_cnt", 32'(a.InstrCount), 32'h1);
        clr_a();
        start_a(10'h020);
        a.BranchOnEq = 1'b1;
        a.EqFlag     = 1'b0;
        a.BrTarget   = 8'hF8;
        tick();
        chk("beq_nt", 32'(a.InstrAddr), 32'h021);
        clr_a();
        start_a(10'h020);
        a.BranchOnNe = 1'b1;
        a.EqFlag     = 1'b0;
        a.BrTarget   = 8'hF8;
        tick();
        chk("bne_tk", 32'(a.InstrAddr), 32'h018);
        clr_a();
        start_a(10'h020);
        a.BranchOnNe = 1'b1;
        a.EqFlag     = 1'b1;
        a.BrTarget   = 8'hF8;
        tick();
        chk("bne_nt", 32'(a.InstrAddr), 32'h021);
        clr_a();
        start_a(10'h020);
        a.BranchOnEq = 1'b1;
        a.BranchOnNe = 1'b1;
        a.EqFlag     = 1'b0;
        a.BrTarget   = 8'h04;
        tick();
        chk("both_tk", 32'(a.InstrAddr), 32'h024);
        clr_a();

        start_a(10'h3FF);
        tick();
        chk("wrap_inc", 32'(a.InstrAddr), 32'h000);
        start_a(10'h3FE);
        a.BranchOnEq = 1'b1;
        a.EqFlag     = 1'b1;
        a.BrTarget   = 8'h05;
        tick();
        chk("wrap_br", 32'(a.InstrAddr), 32'h003);
        clr_a();

        start_a(10'h040);
        tick();
        chk("stl_pre", 32'(a.InstrAddr), 32'h041);
        a.Stall      = 1'b1;
        a.Ack        = 1'b1;
        a.BranchOnEq = 1'b1;
        a.EqFlag     = 1'b1;
        a.BrTarget   = 8'h08;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_pc", 32'(a.InstrAddr), 32'h041);
            chk("stl_cnt", 32'(a.InstrCount), 32'h1);
            chk("stl_run", 32'(a.Running), 32'h1);
        end
        a.Stall = 1'b0;
        tick();
        chk("ack_done", 32'(a.Done), 32'h1);
        chk("ack_run", 32'(a.Running), 32'h0);
        chk("ack_pc", 32'(a.InstrAddr), 32'h041);
        chk("ack_cnt", 32'(a.InstrCount), 32'h2);
        clr_a();

        a.BranchOnNe = 1'b1;
        tick();
        a.BranchOnNe = 1'b0;
        a.Stall      = 1'b1;
        tick();
        a.Stall      = 1'b0;
        a.Ack        = 1'b1;
        tick();
        clr_a();
        tick();
        chk("hlt_pc", 32'(a.InstrAddr), 32'h041);
        chk("hlt_cnt", 32'(a.InstrCount), 32'h2);
        chk("hlt_done", 32'(a.Done), 32'h1);
        start_a(10'h100);
        chk("rs_done", 32'(a.Done), 32'h0);
        chk("rs_run", 32'(a.Running), 32'h1);
        chk("rs_pc", 32'(a.InstrAddr), 32'h100);
        chk("rs_cnt", 32'(a.InstrCount), 32'h0);

        a.Start     = 1'b1;
        a.StartAddr = 10'h123;
        tick();
        tick();
        chk("st_hold", 32'(a.InstrAddr), 32'h123);
        chk("st_cnt", 32'(a.InstrCount), 32'h0);
        a.Start = 1'b0;

        start_a(10'h05A);
        chk("mr_pre", 32'(a.InstrAddr), 32'h05A);
        #2;
        Reset = 1'b0;
        #1;
        chk("mr_pc", 32'(a.InstrAddr), 32'h0);
        chk("mr_run", 32'(a.Running), 32'h0);
        chk("mr_done", 32'(a.Done), 32'h0);
        chk("mr_cnt", 32'(a.InstrCount), 32'h0);
        #1;
        Reset = 1'b1;
        tick();
        chk("mr_idle", 32'(a.InstrAddr), 32'h0);

        start_a(10'h000);
        repeat (65534) tick();
        chk("sat_pre", 32'(a.InstrCount), 32'hFFFE);
        repeat (3) tick();
        chk("sat_hold", 32'(a.InstrCount), 32'hFFFF);

        b.Start     = 1'b1;
        b.StartAddr = 10'h200;
        tick();
        b.Start      = 1'b0;
        b.BranchOnEq = 1'b1;
        b.EqFlag     = 1'b1;
        b.BrTarget   = 8'hF8;
        tick();
        chk("abs_tk", 32'(b.InstrAddr), 32'h0F8);
        b.EqFlag = 1'b0;
        tick();
        chk("abs_nt", 32'(b.InstrAddr), 32'h0F9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_ctr_seq.md
Name: prog_ctr_seq

Overview:
Program-counter sequencer for the 9-bit accumulator core. It sits directly upstream of the instruction ROM and the control decoder, and it consumes the decoder's BranchOnEq, BranchOnNe and Ack outputs together with the ALU equality flag. It holds the PC and runs an IDLE/RUN/HALT state machine driven by Start and Ack. It counts retired instructions and raises Done when the program finishes.

Parameters:
PC_W, 10, PC / instruction-address width (ROM depth 2^PC_W)
OFF_W, 8, width of the signed branch offset
CNT_W, 16, width of the retired-instruction counter
BR_ABS, 0, 0 = PC-relative branch (PC + sign-extended BrTarget); 1 = absolute (BrTarget zero-extended to PC_W)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  level-sampled each cycle; 1 = load StartAddr and run
StartAddr  input  PC_W  program entry address
Stall  input  1  1 = freeze PC/state/counter this cycle
BranchOnEq  input  1  from decoder: conditional branch if EqFlag=1
BranchOnNe  input  1  from decoder: conditional branch if EqFlag=0
Ack  input  1  from decoder: current instruction is DUN
EqFlag  input  1  ALU zero/equal flag, valid in the same cycle
BrTarget  input  OFF_W  branch offset/target (from the branch register/LUT)
InstrAddr  output  PC_W  ROM address = PC register (combinational from the flop)
Running  output  1  1 while state = RUN
Done  output  1  1 while state = HALT
InstrCount  output  CNT_W  retired-instruction count

Behaviour:
- Reset asserted (Reset=0, asynchronous): state=IDLE, PC=0, InstrCount=0, Running=0, Done=0. Reset deasserts synchronously to Clk; first state action occurs on the next rising edge.
- Reset asserted mid-RUN or mid-HALT: all outputs return to their reset values immediately.
- States are IDLE, RUN and HALT. Running and Done are registered decodes of the state.
- Priority in every state: Start > Stall > Ack > branch > increment.
- Start=1 in any state:
  - next PC = StartAddr, InstrCount = 0, state = RUN.
  - The instruction at StartAddr is presented the following cycle.
  - Start held high keeps reloading; execution effectively begins after Start falls.
- IDLE with Start=0: hold all values.
- RUN with Stall=1: PC, state and InstrCount hold. Ack and branch inputs are ignored that cycle.
- RUN with Ack=1: state becomes HALT and PC holds at the DUN address. InstrCount increments once, because DUN counts as retired.
- Branch taken: taken = (BranchOnEq & EqFlag) | (BranchOnNe & ~EqFlag).
  - BR_ABS=0: next PC = PC + sext(BrTarget) mod 2^PC_W.
  - BR_ABS=1: next PC = zext(BrTarget).
- Not taken: next PC = PC + 1 mod 2^PC_W. 2^PC_W−1 wraps to 0 with no flag.
- BranchOnEq and BranchOnNe both set (illegal decode): treat as unconditional taken.
- Ack together with a branch: Ack wins and the branch is discarded.
- Each non-stalled RUN cycle increments InstrCount by 1, saturating at 2^CNT_W−1 (no wrap).
- HALT: Done=1; PC and InstrCount hold; Stall, Ack and branch inputs are ignored. Only Start or Reset leaves HALT.
- Latency: every PC update is one cycle (branch resolved in the same cycle as the decode). There are no delay slots.

Decomposition:
- Shared definitions package: pc_state_t enum {IDLE, RUN, HALT} and the default widths as localparams.
- Natural sub-module: pc_next_calc, purely combinational. It takes PC, taken, BrTarget and BR_ABS and returns the next PC. Keep it separate so it can be unit-tested for wrap and sign extension.
- The state machine and counter stay in prog_ctr_seq.

Test Plan:
- Reset=0 mid-run at PC=0x05A → InstrAddr=0, Running=0, Done=0, InstrCount=0 immediately (asynchronous, no clock needed).
- Start=1 for one cycle with StartAddr=0x010, then 5 cycles with no control → InstrAddr sequence 0x010,0x011..0x015; Running=1; InstrCount=5.
- At PC=0x020, BranchOnEq=1, EqFlag=1, BrTarget=8'hF8 (BR_ABS=0) → next PC=0x018. Same stimulus with EqFlag=0 → PC=0x021. BranchOnNe=1, EqFlag=0 → PC=0x018.
- PC=0x3FF, no branch → PC=0x000. At PC=0x3FE with BrTarget=8'h05 taken → PC=0x003 (wrap).
- Stall=1 for 3 cycles with Ack=1 and a taken branch asserted → PC, InstrCount and state unchanged. Release Stall with Ack=1 → HALT, Done=1, PC held, count +1.
- In HALT, pulse BranchOnNe, Stall and Ack → no change. Start=1 with StartAddr=0x100 → Done=0, Running=1, PC=0x100, InstrCount=0.
- Preload InstrCount to 16'hFFFE, run 3 cycles → InstrCount=16'hFFFF and holds.
